sbox_route_arbiter: RTL
=======================

Name: sbox_route_arbiter

Overview:
- Traffic controller in front of the 4-direction switchbox datapath. Directions are indexed 0=north, 1=west, 2=south, 3=east.
- Each input direction presents a word tagged with a destination direction.
- Each output direction has its own round-robin arbiter among competing inputs and a single-entry output register with valid/ready backpressure.
- Sits between neighbouring tiles and the sbox fabric; shares the four output links among the four input requesters.

Parameters:
- W, 32, data word width per direction.
- NDIR, 4, number of directions; fixed at 4. Any other value is unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  4  bit d = input direction d presents a word.
- in_data  input  4*W  word for direction d at bits [d*W +: W].
- in_dest  input  8  destination direction for input d at bits [d*2 +: 2].
- in_ready  output  4  bit d = word on input d is accepted this cycle.
- out_valid  output  4  bit o = output register o holds a word.
- out_data  output  4*W  word in output register o at bits [o*W +: W].
- out_ready  input  4  downstream of output o accepts this cycle.

Behaviour:
- Transfer rules:
  - Input transfer when in_valid[d] && in_ready[d].
  - Output transfer when out_valid[o] && out_ready[o].
- Request: input d requests output o when in_valid[d]==1 and in_dest[d]==o. U-turn (dest==d) is legal and routed normally.
- Output o can accept when out_valid[o]==0, or when out_valid[o]==1 and out_ready[o]==1 (drain and refill in the same cycle).
- Arbitration per output o, combinational, in the same cycle:
  - If o can accept and has at least one requester, grant the first requester found scanning d = ptr[o], ptr[o]+1, … mod 4.
  - At most one grant per output per cycle.
  - Each input requests exactly one output, so it receives at most one grant.
- in_ready[d] = granted by output in_dest[d].
  - in_ready may depend combinationally on in_valid, in_dest and out_ready. No combinational path from in_data.
  - in_ready is 0 while reset is high.
- Output register update on each rising edge:
  - If granted input g: out_data[o] <= in_data[g], out_valid[o] <= 1, ptr[o] <= (g+1) mod 4. Wraps 3 -> 0.
  - Else if an output transfer occurred: out_valid[o] <= 0.
  - Else: hold. out_data is unchanged while out_valid=1 and out_ready=0.
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N. There is no bypass, so minimum latency is 1 cycle.
- Throughput: 1 word per output per cycle with out_ready held high; up to 4 words per cycle total when destinations do not conflict.
- Ungranted inputs: in_ready stays 0 and the bench must hold in_valid/in_data/in_dest stable. The arbiter keeps no per-input state.
- Reset (synchronous, also when asserted mid-operation):
  - out_valid <= 0 and ptr[0..3] <= 0; any buffered words are discarded.
  - out_data <= 0.
  - in_ready is forced to 0 during the reset cycle.
  - Normal operation resumes on the first edge with reset low.
- Fairness: a continuously requesting input is granted within 4 grants of its target output.

Test Plan:
- Single route: reset, then in_valid=4'b0001, in_data[north]=100, in_dest[north]=3, out_ready=4'b1111 -> in_ready=4'b0001 the same cycle; next cycle out_valid=4'b1000, out_data[east]=100; the cycle after, out_valid=0.
- Full contention: all inputs valid with data N=100, W=200, S=300, E=400, all dest=2, out_ready[2]=1, each input dropped after its transfer -> one grant per cycle in order N,W,S,E; out_data[south]=100,200,300,400 on 4 consecutive cycles; ptr[2] ends at 0.
- Backpressure: north->south data 100 accepted; out_ready[2]=0 for 3 cycles with west->south data 200 pending -> in_ready[west]=0 and out_data[south] holds 100; raising out_ready[2] -> 200 accepted that cycle and appears next cycle.
- Parallel non-conflicting: N->E 100, W->S 200, S->N 300, E->W 400 in one cycle -> in_ready=4'b1111; next cycle out_valid=4'b1111 with onorth=300, owest=400, osouth=200, oeast=100.
- Pointer rotation: east then north both requesting west repeatedly with ptr[1]=3 -> grant east first, ptr[1] wraps to 0, then grant north.
- Reset mid-flight: out_valid=4'b0110 with out_ready=0, assert reset for one cycle -> out_valid=0, in_ready=0 during reset; after release, the first request to west with ptr[1]=0 grants north.

Source files
------------

// File: rtl/sbox_route_arbiter_if.sv
// Handshake bundle between neighbouring tiles and the switchbox route arbiter.
// Input side carries tagged words; output side carries one registered word per direction.
interface sbox_route_arbiter_if #(
    parameter int unsigned W    = 32,
    parameter int unsigned NDIR = 4
);
    logic [NDIR-1:0]   in_valid;
    logic [NDIR*W-1:0] in_data;
    logic [NDIR*2-1:0] in_dest;
    logic [NDIR-1:0]   in_ready;
    logic [NDIR-1:0]   out_valid;
    logic [NDIR*W-1:0] out_data;
    logic [NDIR-1:0]   out_ready;

    modport master (
        output in_valid, in_data, in_dest, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_dest, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sbox_route_arbiter.sv
// Per-output round-robin arbitration of four tagged input words into four
// single-entry output registers with valid/ready backpressure.
module sbox_route_arbiter #(
    parameter int unsigned W    = 32,
    parameter int unsigned NDIR = 4
) (
    input  logic               clk,
    input  logic               reset,
    sbox_route_arbiter_if.slave bus
);
    localparam int unsigned DW = 2;

    logic [NDIR-1:0]         r_out_valid;
    logic [NDIR-1:0][W-1:0]  r_out_data;
    logic [NDIR-1:0][DW-1:0] r_ptr;

    logic [NDIR-1:0][W-1:0]    w_in_words;
    logic [NDIR-1:0][DW-1:0]   w_dest;
    logic [NDIR-1:0][NDIR-1:0] w_req;
    logic [NDIR-1:0]           w_gnt_vld;
    logic [NDIR-1:0][DW-1:0]   w_gnt_idx;
    logic [NDIR-1:0]           w_in_ready;

    assign w_in_words = bus.in_data;

    // Request matrix, indexed [output][input].
    always_comb begin
        w_dest = '0;
        w_req  = '0;
        for (int d = 0; d < NDIR; d++) begin
            w_dest[d] = bus.in_dest[d*DW +: DW];
        end
        for (int o = 0; o < NDIR; o++) begin
            for (int d = 0; d < NDIR; d++) begin
                w_req[o][d] = bus.in_valid[d] && (w_dest[d] == DW'(o));
            end
        end
    end

    // Round-robin scan from r_ptr; an output only grants when its register can take a word.
    always_comb begin
        w_gnt_vld = '0;
        w_gnt_idx = '0;
        for (int o = 0; o < NDIR; o++) begin
            if (!reset && (!r_out_valid[o] || bus.out_ready[o])) begin
                for (int k = 0; k < NDIR; k++) begin
                    if (!w_gnt_vld[o] && w_req[o][r_ptr[o] + DW'(k)]) begin
                        w_gnt_vld[o] = 1'b1;
                        w_gnt_idx[o] = r_ptr[o] + DW'(k);
                    end
                end
            end
        end
    end

    always_comb begin
        w_in_ready = '0;
        for (int d = 0; d < NDIR; d++) begin
            w_in_ready[d] = bus.in_valid[d] && w_gnt_vld[w_dest[d]] &&
                            (w_gnt_idx[w_dest[d]] == DW'(d));
        end
    end

    // Refill beats drain, so a full register with out_ready high stays at full rate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= '0;
            r_out_data  <= '0;
            r_ptr       <= '0;
        end else begin
            for (int o = 0; o < NDIR; o++) begin
                if (w_gnt_vld[o]) begin
                    r_out_data[o]  <= w_in_words[w_gnt_idx[o]];
                    r_out_valid[o] <= 1'b1;
                    r_ptr[o]       <= w_gnt_idx[o] + DW'(1);
                end else if (r_out_valid[o] && bus.out_ready[o]) begin
                    r_out_valid[o] <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
endmodule
